// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops WIDTH-bit words, packs PACK of them into one
// wide beat and hands it downstream over valid/ready; flush emits a partial beat.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CW    = $clog2(PACK + 1)
) (
  input  logic                    rd_clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [WIDTH-1:0]        fifo_rdata,
  output logic                    fifo_rd_en,
  input  logic                    flush,
  output logic [WIDTH*PACK-1:0]   out_data,
  output logic [CW-1:0]           out_words,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {S_FILL, S_FULL, S_DRAIN} state_e;
  typedef logic [PACK-1:0][WIDTH-1:0] pack_t;

  localparam logic [CW:0]   PACK_W = (CW + 1)'(PACK);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  pack_t                 pack_q, pack_d;
  logic [CW-1:0]         lvl_q, lvl_d;
  logic                  pend_q, pend_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [WIDTH*PACK-1:0] out_data_q, out_data_d;
  logic [CW-1:0]         out_words_q, out_words_d;
  logic                  out_valid_q, out_valid_d;

  state_e state;
  logic   fill_room;
  logic   slot_free;

  // Counting the in-flight word keeps the pack register from ever overflowing.
  assign fill_room  = ({1'b0, lvl_q} + {{CW{1'b0}}, pend_q}) < PACK_W;
  assign fifo_rd_en = !rst && !fifo_empty && !flush_pend_q && fill_room;
  assign slot_free  = !out_valid_q || out_ready;
  assign busy       = (lvl_q != '0) || pend_q || flush_pend_q || out_valid_q;

  assign out_data  = out_data_q;
  assign out_words = out_words_q;
  assign out_valid = out_valid_q;

  // A full pack register outranks a pending flush so the full beat goes first.
  always_comb begin
    state = S_FILL;
    if (lvl_q == PACK_C && !pend_q) begin
      state = S_FULL;
    end else if (flush_pend_q) begin
      state = S_DRAIN;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pack_d       = pack_q;
    lvl_d        = lvl_q;
    pend_d       = fifo_rd_en;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_words_d  = out_words_q;
    out_valid_d  = out_valid_q && !out_ready;

    // A flush with nothing captured or on its way is a no-op and is not latched.
    if (flush && (lvl_q != '0 || pend_q || fifo_rd_en)) begin
      flush_pend_d = 1'b1;
    end

    if (pend_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (CW'(i) == lvl_q) pack_d[i] = fifo_rdata;
      end
      lvl_d = lvl_q + CW'(1);
    end

    case (state)
      S_FULL: begin
        if (slot_free) begin
          out_data_d  = pack_q;
          out_words_d = PACK_C;
          out_valid_d = 1'b1;
          lvl_d       = '0;
        end
      end
      S_DRAIN: begin
        if (!pend_q) begin
          if (lvl_q == '0) begin
            flush_pend_d = 1'b0;
          end else if (slot_free) begin
            for (int i = 0; i < PACK; i++) begin
              out_data_d[i*WIDTH +: WIDTH] = (CW'(i) < lvl_q) ? pack_q[i] : '0;
            end
            out_words_d  = lvl_q;
            out_valid_d  = 1'b1;
            lvl_d        = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the pack register is reset along with the control state so stale words
  // can never leak into a beat after reset.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      pack_q       <= '0;
      lvl_q        <= '0;
      pend_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_words_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      pack_q       <= pack_d;
      lvl_q        <= lvl_d;
      pend_q       <= pend_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_words_q  <= out_words_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural FIFO model feeds the DUT, expected beats
// go into a scoreboard queue that an independent monitor drains on each accept.
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int CW    = $clog2(PACK + 1);
  localparam int BW    = WIDTH * PACK;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [CW-1:0] words;
  } beat_t;

  logic             rd_clk     = 1'b0;
  logic             rst        = 1'b1;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             flush      = 1'b0;
  logic             out_ready  = 1'b0;
  logic             fifo_rd_en;
  logic [BW-1:0]    out_data;
  logic [CW-1:0]    out_words;
  logic             out_valid;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] fifo_q[$];
  beat_t            exp_q[$];
  int pops         = 0;
  int cyc          = 0;
  int first_pop    = -1;
  int last_pop     = -1;
  int valid_cycles = 0;
  bit toggle_en    = 1'b0;
  bit force_empty  = 1'b0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
    .rd_clk     (rd_clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_data   (out_data),
    .out_words  (out_words),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: registered read data, empty flag updated one cycle after a change.
  always @(posedge rd_clk) begin
    cyc++;
    if (fifo_rd_en && !fifo_empty && fifo_q.size() > 0) begin
      fifo_rdata <= fifo_q.pop_front();
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    force_empty = toggle_en ? ~force_empty : 1'b0;
    fifo_empty <= (fifo_q.size() == 0) || force_empty;
  end

  always @(negedge rd_clk) begin
    beat_t e;
    if (out_valid) valid_cycles++;
    if (fifo_empty) check("no_pop_when_empty", fifo_rd_en, 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got data 0x%0h words %0d, want no beat", out_data, out_words);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_words", out_words, e.words);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic push_words(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + WIDTH'(i));
  endtask

  task automatic expect_beat(input logic [BW-1:0] d, input int w);
    exp_q.push_back(beat_t'{data: d, words: CW'(w)});
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      if (!busy && !out_valid && fifo_empty && fifo_q.size() == 0 && exp_q.size() == 0)
        done = 1'b1;
    end
    check(name, done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;

    // Reset with a non-empty FIFO: nothing may be popped while rst is high.
    push_words(8'h11, 0);
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    fifo_q.push_back(8'h44);
    tick(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_words", out_words, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_no_pops", pops, 0);

    // Basic full beat, four back-to-back pops, single-cycle valid.
    out_ready    = 1'b1;
    valid_cycles = 0;
    expect_beat(32'h44332211, 4);
    rst = 1'b0;
    wait_idle("t1_idle", 50);
    check("t1_pops", pops, 4);
    check("t1_pop_span", last_pop - first_pop, 3);
    check("t1_valid_cycles", valid_cycles, 1);

    // Backpressure: pops stop with one beat held on the output and one packed.
    out_ready = 1'b0;
    p0 = pops;
    push_words(8'h01, 9);
    tick(20);
    check("t2_pops_stalled", pops - p0, 8);
    check("t2_fifo_left", fifo_q.size(), 1);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_data", out_data, 32'h04030201);
    check("t2_out_words", out_words, 4);
    check("t2_rd_en_blocked", fifo_rd_en, 0);
    tick(5);
    check("t2_out_data_held", out_data, 32'h04030201);
    check("t2_pops_still", pops - p0, 8);
    expect_beat(32'h04030201, 4);
    expect_beat(32'h08070605, 4);
    expect_beat(32'h00000009, 1);
    out_ready = 1'b1;
    tick(6);
    pulse_flush();
    wait_idle("t2_idle", 50);

    // Flush while the third word is in flight; a newly arrived word must wait.
    p0 = pops;
    push_words(8'hA1, 3);
    for (int i = 0; i < 50 && pops - p0 < 3; i++) tick();
    check("t3_pops_reached", pops - p0, 3);
    fifo_q.push_back(8'hB1);
    expect_beat(32'h00A3A2A1, 3);
    expect_beat(32'h000000B1, 1);
    pulse_flush();
    check("t3_no_pop_flush_pend", fifo_rd_en, 0);
    check("t3_busy", busy, 1);
    tick(6);
    pulse_flush();
    wait_idle("t3_idle", 50);

    // Flush with nothing captured: no beat and busy never rises.
    check("t4_busy_before", busy, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_busy_after_flush", busy, 0);
    tick(3);
    check("t4_busy_later", busy, 0);
    check("t4_no_valid", out_valid, 0);
    push_words(8'hAA, 4);
    fifo_q[1] = 8'hBB;
    fifo_q[2] = 8'hCC;
    fifo_q[3] = 8'hDD;
    expect_beat(32'hDDCCBBAA, 4);
    wait_idle("t4_idle", 50);

    // Empty flag toggling every cycle across twelve words.
    toggle_en = 1'b1;
    p0 = pops;
    push_words(8'h10, 12);
    expect_beat(32'h13121110, 4);
    expect_beat(32'h17161514, 4);
    expect_beat(32'h1B1A1918, 4);
    for (int i = 0; i < 300 && pops - p0 < 12; i++) tick();
    check("t5_pops", pops - p0, 12);
    toggle_en = 1'b0;
    wait_idle("t5_idle", 100);

    // Asynchronous reset mid-operation discards the held and packed words.
    out_ready = 1'b0;
    push_words(8'h21, 6);
    tick(15);
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_busy", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_rd_en", fifo_rd_en, 0);
    push_words(8'h31, 4);
    tick(3);
    check("t6_rd_en_in_rst", fifo_rd_en, 0);
    out_ready = 1'b1;
    expect_beat(32'h34333231, 4);
    rst = 1'b0;
    wait_idle("t6_idle", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
